// File: rtl/hsv_core_alu_pipe.sv
// Pipelined integer ALU with tag, illegal-op flag, flush and ready/valid stalling.
// Optional HSV_ALU_PIPE_SKID_EN adds a 2-entry skid buffer with a registered ready.
module hsv_core_alu_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk_core,
  input  logic             rst_core,
  input  logic             flush_req,
  output logic             flush_ack,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       op_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic             use_imm_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             illegal_o
);

  // Handshake: a transfer happens on an edge where valid and ready are both high;
  // valid never depends on ready, and data is held stable while valid waits.
  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0]   op_b;
  logic [SHW-1:0]    shamt;
  logic [XLEN-1:0]   comp_res;
  logic              comp_ill;

  logic [STAGES-1:0] stg_vld;
  logic [STAGES-1:0] stg_ill;
  logic [XLEN-1:0]   stg_res [STAGES];
  logic [TAG_W-1:0]  stg_tag [STAGES];
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] can_load;
  logic              sink_rdy;
  logic              in_fire;

  always_comb begin
    op_b     = use_imm_i ? imm_i : rs2_i;
    shamt    = op_b[SHW-1:0];
    comp_res = '0;
    comp_ill = 1'b0;
    case (op_i)
      4'd0:    comp_res = rs1_i + op_b;
      4'd1:    comp_res = rs1_i - op_b;
      4'd2:    comp_res = rs1_i & op_b;
      4'd3:    comp_res = rs1_i | op_b;
      4'd4:    comp_res = rs1_i ^ op_b;
      4'd5:    comp_res = rs1_i << shamt;
      4'd6:    comp_res = rs1_i >> shamt;
      4'd7:    comp_res = $unsigned($signed(rs1_i) >>> shamt);
      4'd8:    comp_res = {{(XLEN-1){1'b0}}, ($signed(rs1_i) < $signed(op_b))};
      4'd9:    comp_res = {{(XLEN-1){1'b0}}, (rs1_i < op_b)};
      default: comp_ill = 1'b1;
    endcase
  end

  // Ready ripples back from the sink: a stage can load if it is empty or leaving.
  always_comb begin
    adv      = '0;
    can_load = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (k == STAGES - 1) adv[k] = stg_vld[k] & sink_rdy;
      else                 adv[k] = stg_vld[k] & can_load[k+1];
      can_load[k] = ~stg_vld[k] | adv[k];
    end
  end

  assign ready_o = ~flush_req & can_load[0];
  assign in_fire = valid_i & ready_o;

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      flush_ack <= 1'b0;
      stg_vld   <= '0;
      stg_ill   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        stg_res[k] <= '0;
        stg_tag[k] <= '0;
      end
    end else begin
      flush_ack <= flush_req;
      if (flush_req) begin
        stg_vld <= '0;
      end else begin
        if (can_load[0]) begin
          stg_vld[0] <= in_fire;
          if (in_fire) begin
            stg_res[0] <= comp_res;
            stg_tag[0] <= tag_i;
            stg_ill[0] <= comp_ill;
          end
        end
        for (int k = 1; k < STAGES; k++) begin
          if (can_load[k]) begin
            stg_vld[k] <= stg_vld[k-1];
            if (stg_vld[k-1]) begin
              stg_res[k] <= stg_res[k-1];
              stg_tag[k] <= stg_tag[k-1];
              stg_ill[k] <= stg_ill[k-1];
            end
          end
        end
      end
    end
  end

`ifdef HSV_ALU_PIPE_SKID_EN
  logic [XLEN-1:0]  skid_res [2];
  logic [TAG_W-1:0] skid_tag [2];
  logic [1:0]       skid_ill;
  logic             skid_wr;
  logic             skid_rd;
  logic [1:0]       skid_cnt;
  logic [1:0]       skid_cnt_nxt;
  logic             skid_rdy_q;
  logic             skid_push;
  logic             skid_pop;

  // Registered ready cuts the ready_i path; the second entry absorbs the in-flight op.
  assign sink_rdy     = skid_rdy_q & ~flush_req;
  assign skid_push    = adv[STAGES-1];
  assign skid_pop     = (skid_cnt != 2'd0) & ready_i & ~flush_req;
  assign skid_cnt_nxt = skid_cnt + {1'b0, skid_push} - {1'b0, skid_pop};

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      skid_cnt   <= 2'd0;
      skid_wr    <= 1'b0;
      skid_rd    <= 1'b0;
      skid_rdy_q <= 1'b1;
      skid_ill   <= '0;
      for (int k = 0; k < 2; k++) begin
        skid_res[k] <= '0;
        skid_tag[k] <= '0;
      end
    end else if (flush_req) begin
      skid_cnt   <= 2'd0;
      skid_wr    <= 1'b0;
      skid_rd    <= 1'b0;
      skid_rdy_q <= 1'b1;
    end else begin
      if (skid_push) begin
        skid_res[skid_wr] <= stg_res[STAGES-1];
        skid_tag[skid_wr] <= stg_tag[STAGES-1];
        skid_ill[skid_wr] <= stg_ill[STAGES-1];
        skid_wr           <= ~skid_wr;
      end
      if (skid_pop) skid_rd <= ~skid_rd;
      skid_cnt   <= skid_cnt_nxt;
      skid_rdy_q <= (skid_cnt_nxt != 2'd2);
    end
  end

  assign valid_o   = (skid_cnt != 2'd0) & ~flush_req;
  assign result_o  = skid_res[skid_rd];
  assign tag_o     = skid_tag[skid_rd];
  assign illegal_o = skid_ill[skid_rd];
`else
  assign sink_rdy  = ready_i & ~flush_req;
  assign valid_o   = stg_vld[STAGES-1] & ~flush_req;
  assign result_o  = stg_res[STAGES-1];
  assign tag_o     = stg_tag[STAGES-1];
  assign illegal_o = stg_ill[STAGES-1];
`endif

endmodule

// File: tb/tb_hsv_core_alu_pipe.sv
// Directed bench for hsv_core_alu_pipe (XLEN=32, STAGES=2): queue-based model
// checked every cycle on the falling edge, plus literal spot checks.
module tb_hsv_core_alu_pipe;
  localparam int XLEN   = 32;
  localparam int STAGES = 2;
  localparam int TAG_W  = 4;

  logic             clk_core = 1'b0;
  logic             rst_core;
  logic             flush_req;
  logic             flush_ack;
  logic             valid_i;
  logic             ready_o;
  logic [3:0]       op_i;
  logic [XLEN-1:0]  rs1_i;
  logic [XLEN-1:0]  rs2_i;
  logic [XLEN-1:0]  imm_i;
  logic             use_imm_i;
  logic [TAG_W-1:0] tag_i;
  logic             valid_o;
  logic             ready_i;
  logic [XLEN-1:0]  result_o;
  logic [TAG_W-1:0] tag_o;
  logic             illegal_o;

  int checks = 0;
  int errors = 0;

  // model state: one entry per op in flight, oldest first
  logic [XLEN-1:0]  exp_q[$];
  logic [TAG_W-1:0] exp_tag_q[$];
  logic             exp_ill_q[$];
  int               age_q[$];
  logic             exp_ack;

  hsv_core_alu_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk_core(clk_core), .rst_core(rst_core), .flush_req(flush_req), .flush_ack(flush_ack),
    .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .imm_i(imm_i), .use_imm_i(use_imm_i), .tag_i(tag_i), .valid_o(valid_o),
    .ready_i(ready_i), .result_o(result_o), .tag_o(tag_o), .illegal_o(illegal_o)
  );

  // clock / reset
  always #5 clk_core = ~clk_core;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // {illegal, result} from the ISA definition of each opcode
  function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    logic [31:0] r;
    sh = int'(b[4:0]);
    r  = 32'h0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << sh;
      4'd6: r = a >> sh;
      4'd7: r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      4'd8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: r = (a < b) ? 32'd1 : 32'd0;
      default: return {1'b1, 32'h0};
    endcase
    return {1'b0, r};
  endfunction

  // scoreboard: check on the falling edge, then advance the model for the next rising edge
  always @(negedge clk_core) begin
    logic        exp_v;
    logic        exp_rdy;
    logic [32:0] r;
    if (rst_core) begin
      exp_q.delete(); exp_tag_q.delete(); exp_ill_q.delete(); age_q.delete();
      exp_ack = 1'b0;
      chk("rst_valid_o", 64'(valid_o), 64'(0));
      chk("rst_ready_o", 64'(ready_o), 64'(!flush_req));
      chk("rst_result_o", 64'(result_o), 64'(0));
      chk("rst_tag_o", 64'(tag_o), 64'(0));
      chk("rst_illegal_o", 64'(illegal_o), 64'(0));
      chk("rst_flush_ack", 64'(flush_ack), 64'(0));
    end else begin
      exp_v   = (exp_q.size() > 0) && (age_q[0] >= STAGES - 1) && !flush_req;
      exp_rdy = !flush_req && ((exp_q.size() < STAGES) || (exp_v && ready_i));
      chk("valid_o", 64'(valid_o), 64'(exp_v));
      chk("ready_o", 64'(ready_o), 64'(exp_rdy));
      chk("flush_ack", 64'(flush_ack), 64'(exp_ack));
      if (exp_v) begin
        chk("result_o", 64'(result_o), 64'(exp_q[0]));
        chk("tag_o", 64'(tag_o), 64'(exp_tag_q[0]));
        chk("illegal_o", 64'(illegal_o), 64'(exp_ill_q[0]));
      end
      if (flush_req) begin
        exp_q.delete(); exp_tag_q.delete(); exp_ill_q.delete(); age_q.delete();
      end else begin
        if (exp_v && ready_i) begin
          void'(exp_q.pop_front()); void'(exp_tag_q.pop_front());
          void'(exp_ill_q.pop_front()); void'(age_q.pop_front());
        end
        foreach (age_q[i]) if (age_q[i] < STAGES) age_q[i]++;
        if (valid_i && exp_rdy) begin
          r = ref_alu(op_i, rs1_i, use_imm_i ? imm_i : rs2_i);
          exp_q.push_back(r[31:0]);
          exp_tag_q.push_back(tag_i);
          exp_ill_q.push_back(r[32]);
          age_q.push_back(0);
        end
      end
      exp_ack = flush_req;
    end
  end

  // driver: present one op and hold it until accepted
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic sel_imm, input logic [3:0] tag);
    logic accepted;
    op_i      = op;
    rs1_i     = a;
    use_imm_i = sel_imm;
    rs2_i     = sel_imm ? $urandom() : b;
    imm_i     = sel_imm ? b : $urandom();
    tag_i     = tag;
    valid_i   = 1'b1;
    accepted  = 1'b0;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk_core);
      accepted = ready_o;
      @(posedge clk_core);
      #1;
    end
    if (!accepted) chk("send_timeout", 64'(0), 64'(1));
    valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk_core);
      #1;
    end
    chk("drain", 64'(exp_q.size()), 64'(0));
  endtask

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        sel_imm;
    logic [3:0]  tag;
  } vec_t;

  vec_t vecs[10];

  initial begin
    rst_core = 1'b1; flush_req = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    op_i = 4'd0; rs1_i = '0; rs2_i = '0; imm_i = '0; use_imm_i = 1'b0; tag_i = '0;
    repeat (2) @(posedge clk_core);
    #1 rst_core = 1'b0;

    // pin the model against hand-computed values
    chk("pin_add", 64'(ref_alu(4'd0, 32'h7FFF_FFFF, 32'd1)), 64'(33'h0_8000_0000));
    chk("pin_or", 64'(ref_alu(4'd3, 32'h5A5A_5A5A, 32'h0F0F_0F0F)), 64'(33'h0_5F5F_5F5F));
    chk("pin_sra", 64'(ref_alu(4'd7, 32'h8000_0000, 32'd4)), 64'(33'h0_F800_0000));
    chk("pin_sltu", 64'(ref_alu(4'd9, 32'd1, 32'hFFFF_FFFF)), 64'(33'h0_0000_0001));
    chk("pin_slt", 64'(ref_alu(4'd8, 32'hFFFF_FFFF, 32'd1)), 64'(33'h0_0000_0001));
    chk("pin_illegal", 64'(ref_alu(4'd12, 32'h1234, 32'h5678)), 64'(33'h1_0000_0000));

    // latency: accepted at edge N, visible after edge N+1
    send(4'd0, 32'h7FFF_FFFF, 32'd1, 1'b0, 4'd3);
    chk("lat_early_valid", 64'(valid_o), 64'(0));
    @(posedge clk_core); #1;
    chk("lat_valid", 64'(valid_o), 64'(1));
    chk("lat_result", 64'(result_o), 64'(32'h8000_0000));
    chk("lat_tag", 64'(tag_o), 64'(3));
    chk("lat_illegal", 64'(illegal_o), 64'(0));
    wait_drain();

    // back-to-back stream
    vecs[0] = '{4'd3, 32'h5A5A_5A5A, 32'h0F0F_0F0F, 1'b1, 4'd1};
    vecs[1] = '{4'd7, 32'h8000_0000, 32'd4, 1'b0, 4'd2};
    vecs[2] = '{4'd9, 32'd1, 32'hFFFF_FFFF, 1'b0, 4'd4};
    vecs[3] = '{4'd1, 32'd0, 32'd1, 1'b0, 4'd5};
    vecs[4] = '{4'd5, 32'h0000_0001, 32'h0000_003F, 1'b1, 4'd6};
    vecs[5] = '{4'd6, 32'h8000_0000, 32'd31, 1'b0, 4'd7};
    vecs[6] = '{4'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0, 4'd8};
    vecs[7] = '{4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 4'd9};
    vecs[8] = '{4'd8, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 4'd10};
    vecs[9] = '{4'd9, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'd11};
    foreach (vecs[i]) send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sel_imm, vecs[i].tag);
    wait_drain();

    // backpressure: three ops against a stalled sink
    ready_i = 1'b0;
    fork
      begin
        send(4'd0, 32'd10, 32'd20, 1'b0, 4'd1);
        send(4'd1, 32'd10, 32'd20, 1'b0, 4'd2);
        send(4'd4, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 4'd3);
      end
      begin
        repeat (6) @(posedge clk_core);
        #1 ready_i = 1'b1;
      end
    join
    wait_drain();

    // flush while stalled with two ops in flight
    ready_i = 1'b0;
    send(4'd0, 32'd1, 32'd2, 1'b0, 4'd12);
    send(4'd0, 32'd3, 32'd4, 1'b0, 4'd13);
    @(posedge clk_core); #1;
    flush_req = 1'b1;
    @(negedge clk_core);
    chk("flush_valid_o", 64'(valid_o), 64'(0));
    chk("flush_ready_o", 64'(ready_o), 64'(0));
    @(posedge clk_core); #1;
    flush_req = 1'b0;
    chk("flush_ack_set", 64'(flush_ack), 64'(1));
    ready_i = 1'b1;
    repeat (4) @(posedge clk_core);
    #1 chk("flush_empty", 64'(valid_o), 64'(0));
    chk("flush_ack_clr", 64'(flush_ack), 64'(0));

    // illegal opcode
    send(4'd12, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 4'd9);
    @(posedge clk_core); #1;
    chk("ill_valid", 64'(valid_o), 64'(1));
    chk("ill_result", 64'(result_o), 64'(0));
    chk("ill_flag", 64'(illegal_o), 64'(1));
    chk("ill_tag", 64'(tag_o), 64'(9));
    wait_drain();

    // reset with a full, stalled pipe
    ready_i = 1'b0;
    send(4'd0, 32'd100, 32'd1, 1'b0, 4'd14);
    send(4'd0, 32'd200, 32'd1, 1'b0, 4'd15);
    rst_core = 1'b1;
    #1;
    chk("arst_valid_o", 64'(valid_o), 64'(0));
    chk("arst_result_o", 64'(result_o), 64'(0));
    chk("arst_tag_o", 64'(tag_o), 64'(0));
    @(posedge clk_core); #1;
    rst_core = 1'b0;
    ready_i  = 1'b1;
    send(4'd0, 32'd5, 32'd6, 1'b0, 4'd7);
    @(posedge clk_core); #1;
    chk("post_rst_valid", 64'(valid_o), 64'(1));
    chk("post_rst_result", 64'(result_o), 64'(11));
    chk("post_rst_tag", 64'(tag_o), 64'(7));
    wait_drain();

    repeat (2) @(posedge clk_core);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
